xy_dac_spi: RTL and testbench
=============================

XY_DAC_SPI -- requirements
Module: xy_dac_spi

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9, giving the width of each X/Y input sample.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in i_clk cycles; the legal range is 1..255.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: upstream has an X/Y sample pair on i_x/i_y.
REQ-006 The block SHALL have port i_x, input, DATA_WIDTH bits: X sample (unsigned).
REQ-007 The block SHALL have port i_y, input, DATA_WIDTH bits: Y sample (unsigned).
REQ-008 The block SHALL have port o_ready, output, 1 bit: the block can accept a pair this cycle.
REQ-009 The block SHALL have ports o_sclk, o_mosi and o_cs_n, outputs, 1 bit each: SPI to a dual 12-bit DAC, mode 0.
REQ-010 The block SHALL have port o_ldac_n, output, 1 bit: DAC latch strobe, active-low.
REQ-011 The block SHALL have port o_busy, output, 1 bit: a pair is being transferred (equal to !o_ready).

Function
REQ-012 The block SHALL accept a pair in any cycle where i_valid && o_ready, capturing i_x and i_y into internal registers.
REQ-013 The block SHALL ignore and not buffer i_valid while o_ready is low; the upstream streamer is allowed to drop samples.
REQ-014 The state machine SHALL have the states IDLE, FRAME_X, GAP_X, FRAME_Y, GAP_Y and LDAC.
- Transitions: IDLE->FRAME_X on accept; FRAME_X->GAP_X; GAP_X->FRAME_Y; FRAME_Y->GAP_Y; GAP_Y->LDAC; LDAC->IDLE.
REQ-015 o_ready SHALL be 1 only in IDLE.
REQ-016 Each frame SHALL be 16 bits, MSB first: a 4-bit header followed by the sample left-justified to 12 bits ({sample, 12-DATA_WIDTH zeros}).
- X header: 4'b0011.
- Y header: 4'b1011.
REQ-017 o_cs_n SHALL be 0 for exactly 32*CLK_DIV cycles per frame, starting in the cycle after entering FRAME_x.
REQ-018 o_sclk SHALL idle at 0 and toggle every CLK_DIV cycles while o_cs_n is 0, giving 16 rising edges per frame.
- The frame ends with o_sclk at 0.
REQ-019 o_mosi SHALL present bit 15 when o_cs_n falls and change only on falling o_sclk edges, so it is stable at every rising edge.
REQ-020 o_mosi SHALL be 0 whenever o_cs_n is 1.
REQ-021 GAP_X and GAP_Y SHALL each hold o_cs_n at 1 for CLK_DIV cycles.
REQ-022 LDAC SHALL drive o_ldac_n to 0 for CLK_DIV cycles, then return to IDLE.
REQ-023 With the latch stage enabled, accept-to-o_ready-high latency SHALL be 67*CLK_DIV+1 cycles (269 at CLK_DIV=4).
REQ-024 A new pair presented in the first IDLE cycle SHALL be accepted immediately, with no idle bubble.
REQ-025 The internal bit counter and divider SHALL be sized from CLK_DIV and 16, with no wrap or truncation for any legal CLK_DIV.

Reset
REQ-026 While i_rst is 1, the block SHALL hold state IDLE, o_ready=1, o_busy=0, o_sclk=0, o_mosi=0, o_cs_n=1, o_ldac_n=1, and clear the divider, bit counter and sample registers.
REQ-027 Assertion of i_rst mid-frame SHALL immediately force the reset values, aborting the transfer with no LDAC pulse.
REQ-028 After reset release, the first accept SHALL be possible on the first i_clk rising edge.

Configuration
REQ-029 Macro XY_DAC_LDAC_EN defined: the LDAC state and o_ldac_n pulse SHALL be implemented as in REQ-022, giving simultaneous X/Y update.
REQ-030 Macro XY_DAC_LDAC_EN undefined: o_ldac_n SHALL be tied to 0 (DAC updates on each CS rising edge), GAP_Y SHALL go directly to IDLE, and latency SHALL be 66*CLK_DIV+1 cycles (265 at CLK_DIV=4).

Verification
REQ-031 Reset, then i_x=9'h1FF, i_y=9'h000 for one cycle -> X frame shifts 16'h3FF8, Y frame shifts 16'hB000, one o_ldac_n low pulse of 4 cycles.
REQ-032 i_x=9'h155, i_y=9'h0AA -> X frame 16'h3AA8, Y frame 16'hB550, MOSI stable across every SCLK rising edge, 16 rising edges per frame.
REQ-033 i_valid held at 1 with a new pair every cycle -> exactly one pair accepted per 269 cycles; intermediate pairs are dropped and o_ready pulses for exactly 1 cycle between transfers.
REQ-034 i_rst asserted during bit 7 of the Y frame -> the same cycle shows o_cs_n=1, o_sclk=0, o_ldac_n=1, o_ready=1; the next accept produces a complete, correct transfer.
REQ-035 CLK_DIV=1 with XY_DAC_LDAC_EN undefined -> SCLK period of 2 cycles, o_ldac_n constant 0, latency 67 cycles.

Source files
------------

// File: rtl/xy_dac_spi.sv
// ============================================================================
// xy_dac_spi : X/Y sample pair to dual 12-bit DAC serialiser, SPI mode 0.
// Optional macro XY_DAC_LDAC_EN adds the LDAC latch pulse for simultaneous X/Y
// update. Revision: 1.0
// ============================================================================
`default_nettype none

module xy_dac_spi #(
  parameter int DATA_WIDTH = 9,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_y,
  output logic                  o_ready,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_ldac_n,
  output logic                  o_busy
);

  localparam int C_FRAME_BITS = 16;
  localparam int C_HALVES     = 2 * C_FRAME_BITS;
  localparam int C_HALF_W     = $clog2(C_HALVES);
  localparam int C_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(CLK_DIV - 1);
  localparam logic [C_HALF_W-1:0] C_HALF_LAST = C_HALF_W'(C_HALVES - 1);
  localparam logic [3:0] C_HDR_X = 4'b0011;
  localparam logic [3:0] C_HDR_Y = 4'b1011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_X = 3'd1,
    GAP_X   = 3'd2,
    FRAME_Y = 3'd3,
    GAP_Y   = 3'd4,
    LDAC    = 3'd5
  } state_t;

  state_t                  r_state;
  logic [C_DIV_W-1:0]      r_div;
  logic [C_HALF_W-1:0]     r_half;
  logic [DATA_WIDTH-1:0]   r_x;
  logic [DATA_WIDTH-1:0]   r_y;
  logic                    r_ready;
  logic                    r_sclk;
  logic                    r_mosi;
  logic                    r_cs_n;
`ifdef XY_DAC_LDAC_EN
  logic                    r_ldac_n;
`endif
  logic                    w_div_end;
  logic [C_FRAME_BITS-1:0] w_word;
  logic                    w_next_bit;

  function automatic logic [C_FRAME_BITS-1:0] frame_word(input logic [3:0] hdr,
                                                         input logic [DATA_WIDTH-1:0] s);
    logic [C_FRAME_BITS-1:0] w;
    w = {hdr, 12'h000};
    w[11 -: DATA_WIDTH] = s;
    return w;
  endfunction

  // Bit 15 is always the header MSB, so frames start from a constant and the
  // remaining bits are picked from the held samples by the half-period index.
  always_comb begin
    w_word = frame_word(C_HDR_X, r_x);
    if (r_state == FRAME_Y) w_word = frame_word(C_HDR_Y, r_y);
  end

  assign w_div_end  = (r_div == C_DIV_LAST);
  assign w_next_bit = w_word[4'd14 - r_half[C_HALF_W-1:1]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_half   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_ready  <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_cs_n   <= 1'b1;
`ifdef XY_DAC_LDAC_EN
      r_ldac_n <= 1'b1;
`endif
    end else begin
      r_div <= w_div_end ? '0 : r_div + C_DIV_W'(1);
      case (r_state)
        IDLE: begin
          r_div <= '0;
          if (i_valid) begin
            r_x     <= i_x;
            r_y     <= i_y;
            r_half  <= '0;
            r_cs_n  <= 1'b0;
            r_mosi  <= C_HDR_X[3];
            r_ready <= 1'b0;
            r_state <= FRAME_X;
          end
        end
        FRAME_X, FRAME_Y: begin
          if (w_div_end) begin
            if (r_half == C_HALF_LAST) begin
              r_cs_n  <= 1'b1;
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= (r_state == FRAME_X) ? GAP_X : GAP_Y;
            end else begin
              r_half <= r_half + C_HALF_W'(1);
              r_sclk <= ~r_sclk;
              if (r_sclk) r_mosi <= w_next_bit;
            end
          end
        end
        GAP_X: begin
          if (w_div_end) begin
            r_half  <= '0;
            r_cs_n  <= 1'b0;
            r_mosi  <= C_HDR_Y[3];
            r_state <= FRAME_Y;
          end
        end
        GAP_Y: begin
          if (w_div_end) begin
`ifdef XY_DAC_LDAC_EN
            r_ldac_n <= 1'b0;
            r_state  <= LDAC;
`else
            r_ready  <= 1'b1;
            r_state  <= IDLE;
`endif
          end
        end
`ifdef XY_DAC_LDAC_EN
        LDAC: begin
          if (w_div_end) begin
            r_ldac_n <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= IDLE;
          end
        end
`endif
        default: begin
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_busy   = ~r_ready;
  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_cs_n   = r_cs_n;
`ifdef XY_DAC_LDAC_EN
  assign o_ldac_n = r_ldac_n;
`else
  assign o_ldac_n = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xy_dac_spi.sv
// ============================================================================
// tb_xy_dac_spi : directed bench with a cycle-level behavioural model of the
// serialiser, run at CLK_DIV=4 and CLK_DIV=1. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_xy_dac_spi;

  localparam int DW = 9;
  localparam int CD = 4;
`ifdef XY_DAC_LDAC_EN
  localparam bit LD   = 1'b1;
  localparam int LAT0 = 269;
  localparam int LAT1 = 68;
`else
  localparam bit LD   = 1'b0;
  localparam int LAT0 = 265;
  localparam int LAT1 = 67;
`endif
  localparam int BUSY0 = (LD ? 67 : 66) * CD;
  localparam int BUSY1 = (LD ? 67 : 66);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0, valid1 = 1'b0;
  logic [DW-1:0] x = '0, y = '0, x1 = '0, y1 = '0;
  logic ready, busy, sclk, mosi, cs_n, ldac_n;
  logic ready1, busy1, sclk1, mosi1, cs_n1, ldac_n1;

  always #5 clk = ~clk;

  xy_dac_spi #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_x(x), .i_y(y),
    .o_ready(ready), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n),
    .o_ldac_n(ldac_n), .o_busy(busy));

  xy_dac_spi #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .i_x(x1), .i_y(y1),
    .o_ready(ready1), .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs_n1),
    .o_ldac_n(ldac_n1), .o_busy(busy1));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fw(input logic [3:0] h, input logic [DW-1:0] s);
    return 16'((int'(h) << 12) | (int'(s) << (12 - DW)));
  endfunction

  // Expected {ready, busy, sclk, mosi, cs_n, ldac_n} k cycles after the accept cycle.
  function automatic logic [5:0] model(input int k, input int cd,
                                       input logic [15:0] wx, input logic [15:0] wy);
    int blen, j, h;
    logic r, s, m, c, l;
    blen = (LD ? 67 : 66) * cd;
    r = 1'b1; s = 1'b0; m = 1'b0; c = 1'b1; l = LD;
    h = 0;
    if (k >= 1 && k <= blen) r = 1'b0;
    j = -1;
    if (k >= 1 && k <= 32 * cd) j = k - 1;
    else if (k >= 33 * cd + 1 && k <= 65 * cd) j = k - (33 * cd + 1);
    if (j >= 0) begin
      h = j / cd;
      c = 1'b0;
      s = h[0];
      m = (k <= 32 * cd) ? wx[15 - h / 2] : wy[15 - h / 2];
    end
    if (LD && k >= 66 * cd + 1 && k <= 67 * cd) l = 1'b0;
    return {r, ~r, s, m, c, l};
  endfunction

  // Single compare process: the model decides acceptance on its own.
  int cyc = 0, acc0 = -1, acc1 = -1;
  logic [15:0] wx0 = '0, wy0 = '0, wx1 = '0, wy1 = '0;
  always @(posedge clk) begin
    if (rst) begin
      acc0 = -1;
      acc1 = -1;
    end else begin
      if (valid && (acc0 < 0 || cyc - acc0 > BUSY0)) begin
        acc0 = cyc; wx0 = fw(4'h3, x); wy0 = fw(4'hB, y);
      end
      if (valid1 && (acc1 < 0 || cyc - acc1 > BUSY1)) begin
        acc1 = cyc; wx1 = fw(4'h3, x1); wy1 = fw(4'hB, y1);
      end
    end
    cyc++;
    #1;
    check($sformatf("dut0 {rdy,bsy,sclk,mosi,cs_n,ldac_n} cyc %0d", cyc),
          {26'd0, ready, busy, sclk, mosi, cs_n, ldac_n},
          {26'd0, model(acc0 < 0 ? 0 : cyc - acc0, CD, wx0, wy0)});
    check($sformatf("dut1 {rdy,bsy,sclk,mosi,cs_n,ldac_n} cyc %0d", cyc),
          {26'd0, ready1, busy1, sclk1, mosi1, cs_n1, ldac_n1},
          {26'd0, model(acc1 < 0 ? 0 : cyc - acc1, 1, wx1, wy1)});
  end

  // Independent SPI receiver on dut0: frames as seen at SCLK rising edges.
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [15:0] sh = '0;
  int          edges = 0, ldac_run = 0, ldac_last = 0;
  logic [15:0] frames[$];
  int          fedges[$];
  always @(negedge clk) begin
    if (!cs_n && prev_cs) begin sh = '0; edges = 0; end
    if (!cs_n && sclk && !prev_sclk) begin sh = {sh[14:0], mosi}; edges++; end
    if (cs_n && !prev_cs) begin frames.push_back(sh); fedges.push_back(edges); end
    if (!ldac_n) ldac_run++;
    else if (ldac_run > 0) begin ldac_last = ldac_run; ldac_run = 0; end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  // Caller is at a negedge with dut0 idle; returns cycles from accept to ready.
  task automatic send0(input logic [DW-1:0] xv, input logic [DW-1:0] yv, output int lat);
    valid = 1'b1; x = xv; y = yv;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!ready && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic check_frames(input string tag, input logic [15:0] ex, input logic [15:0] ey);
    check({tag, " frame count"}, frames.size(), 2);
    if (frames.size() >= 2) begin
      check({tag, " X frame"}, frames[0], ex);
      check({tag, " Y frame"}, frames[1], ey);
      check({tag, " X rising edges"}, fedges[0], 16);
      check({tag, " Y rising edges"}, fedges[1], 16);
    end
    check({tag, " ldac pulse"}, ldac_last, LD ? CD : 0);
    frames.delete(); fedges.delete(); ldac_last = 0;
  endtask

  initial begin
    int lat, k, n_acc, last_i;
    @(negedge clk);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset sclk", sclk, 0);
    check("reset mosi", mosi, 0);
    check("reset cs_n", cs_n, 1);
    check("reset ldac_n", ldac_n, LD);
    check("reset ready dut1", ready1, 1);
    @(negedge clk);
    rst = 1'b0;
    ldac_run = 0; ldac_last = 0;

    // First pair on the first edge after release.
    send0(9'h1FF, 9'h000, lat);
    check("latency 1FF/000", lat, LAT0);
    check_frames("1FF/000", 16'h3FF8, 16'hB000);

    send0(9'h155, 9'h0AA, lat);
    check("latency 155/0AA", lat, LAT0);
    check_frames("155/0AA", 16'h3AA8, 16'hB550);

    // Streaming: valid held high, fresh data every cycle.
    valid = 1'b1; x = 9'h011; y = 9'h1E0;
    n_acc = 1; last_i = -1;
    for (int i = 0; i < 3 * LAT0 + 5; i++) begin
      @(negedge clk);
      if (ready) begin
        check("stream accept spacing", i - last_i, LAT0);
        last_i = i;
        n_acc++;
      end
      x = x + DW'(1);
      y = y - DW'(3);
    end
    valid = 1'b0;
    check("stream accept count", n_acc, 4);
    k = 0;
    while (!ready && k < 2000) begin @(negedge clk); k++; end
    check("stream drains to idle", ready, 1);
    frames.delete(); fedges.delete(); ldac_last = 0;

    // Abort during bit 7 of the Y frame.
    valid = 1'b1; x = 9'h155; y = 9'h0AA;
    @(negedge clk);
    valid = 1'b0;
    k = 1;
    while (k < 49 * CD + 2) begin @(negedge clk); k++; end
    check("mid Y frame cs_n", cs_n, 0);
    #2 rst = 1'b1;
    #1;
    check("abort cs_n", cs_n, 1);
    check("abort sclk", sclk, 0);
    check("abort mosi", mosi, 0);
    check("abort ldac_n", ldac_n, LD);
    check("abort ready", ready, 1);
    check("abort busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    frames.delete(); fedges.delete(); ldac_last = 0; ldac_run = 0;
    send0(9'h0C3, 9'h13C, lat);
    check("latency after abort", lat, LAT0);
    check_frames("after abort", 16'h3618, 16'hB9E0);

    // CLK_DIV=1 instance.
    valid1 = 1'b1; x1 = 9'h0F3; y1 = 9'h10C;
    @(negedge clk);
    valid1 = 1'b0;
    lat = 1;
    while (!ready1 && lat < 500) begin @(negedge clk); lat++; end
    check("latency CLK_DIV=1", lat, LAT1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, required completion before 1 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
